// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcode/funct constants,
// FSM state encoding, internal ALU-op encoding and the instruction decoder.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_HALT
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT,
      ALU_NOP
   } alu_op_e;

   typedef struct packed {
      alu_op_e op;
      logic    use_imm;  // B operand is the sign-extended immediate
      logic    dest_rt;  // destination is rt rather than rd
      logic    writes;   // instruction targets a register
      logic    ovf_chk;  // signed overflow suppresses the write
      logic    halt;
   } dec_t;

   // Unknown op/funct decodes to a non-writing NOP that still retires.
   function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct);
      dec_t d;
      d.op      = ALU_NOP;
      d.use_imm = 1'b0;
      d.dest_rt = 1'b0;
      d.writes  = 1'b0;
      d.ovf_chk = 1'b0;
      d.halt    = 1'b0;
      case (op)
         OP_RTYPE: begin
            d.writes = 1'b1;
            case (funct)
               FN_ADD: begin d.op = ALU_ADD; d.ovf_chk = 1'b1; end
               FN_SUB: begin d.op = ALU_SUB; d.ovf_chk = 1'b1; end
               FN_AND: d.op = ALU_AND;
               FN_OR:  d.op = ALU_OR;
               FN_SLT: d.op = ALU_SLT;
               default: d.writes = 1'b0;
            endcase
         end
         OP_ADDI: begin
            d.op      = ALU_ADD;
            d.use_imm = 1'b1;
            d.dest_rt = 1'b1;
            d.writes  = 1'b1;
            d.ovf_chk = 1'b1;
         end
         OP_HALT: d.halt = 1'b1;
         default: d.dest_rt = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mips_regfile.sv
// Register file: 2^RegAddrSize x DataSize, two asynchronous read ports,
// one synchronous write port. Register 0 always reads zero and ignores writes.
// Ports: clk, rst_n (async, active-low, clears all entries), ra1/rd1, ra2/rd2
// read ports, we/wa/wd write port.
module mips_regfile #(
   parameter int unsigned DataSize    = 32,
   parameter int unsigned RegAddrSize = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [RegAddrSize-1:0] ra1,
   input  logic [RegAddrSize-1:0] ra2,
   output logic [DataSize-1:0]    rd1,
   output logic [DataSize-1:0]    rd2,
   input  logic                   we,
   input  logic [RegAddrSize-1:0] wa,
   input  logic [DataSize-1:0]    wd
);

   localparam int unsigned NumRegs = 2 ** RegAddrSize;

   logic [DataSize-1:0] regs [NumRegs];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NumRegs; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: FETCH/DECODE/EXECUTE/WRITEBACK FSM with a PC register,
// req/ack instruction fetch, ADD/SUB/AND/OR/SLT, ADDI and HALT.
// Ports: clk, rst_n (async, active-low); imem_req/imem_addr/imem_ack/imem_rdata
// fetch handshake; retire_valid/we/wa/wd retirement report (held between
// pulses); pc; overflow_sticky; halted.
module mips_multicycle_core
   import mips_pkg::*;
#(
   parameter int unsigned DataSize    = 32,
   parameter int unsigned PCsize      = 6,
   parameter int unsigned RegAddrSize = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   imem_req,
   output logic [PCsize-1:0]      imem_addr,
   input  logic                   imem_ack,
   input  logic [31:0]            imem_rdata,
   output logic                   retire_valid,
   output logic                   retire_we,
   output logic [RegAddrSize-1:0] retire_wa,
   output logic [DataSize-1:0]    retire_wd,
   output logic [PCsize-1:0]      pc,
   output logic                   overflow_sticky,
   output logic                   halted
);

   localparam int unsigned Msb = DataSize - 1;

   state_e                 state_q, state_d;
   logic                   req_q, req_d;
   logic [PCsize-1:0]      pc_q;
   logic [31:0]            ir_q;
   logic [DataSize-1:0]    a_q, b_q;
   logic                   retire_valid_q, retire_we_q, ovf_q;
   logic [RegAddrSize-1:0] retire_wa_q;
   logic [DataSize-1:0]    retire_wd_q;

   logic [RegAddrSize-1:0] rs, rt, rd, dest;
   logic [DataSize-1:0]    rf_a, rf_b, imm_ext, opb, alu_res;
   logic                   alu_ovf, exec_we;
   dec_t                   dec;

   assign rs      = RegAddrSize'(ir_q[25:21]);
   assign rt      = RegAddrSize'(ir_q[20:16]);
   assign rd      = RegAddrSize'(ir_q[15:11]);
   assign imm_ext = DataSize'(signed'(ir_q[15:0]));
   assign dec     = decode(ir_q[31:26], ir_q[5:0]);
   assign opb     = dec.use_imm ? imm_ext : b_q;
   assign dest    = dec.dest_rt ? rt : rd;
   assign exec_we = dec.writes && !(dec.ovf_chk && alu_ovf) && (dest != '0);

   mips_regfile #(
      .DataSize   (DataSize),
      .RegAddrSize(RegAddrSize)
   ) u_regfile (
      .clk  (clk),
      .rst_n(rst_n),
      .ra1  (rs),
      .ra2  (rt),
      .rd1  (rf_a),
      .rd2  (rf_b),
      .we   ((state_q == S_WB) && retire_we_q),
      .wa   (retire_wa_q),
      .wd   (retire_wd_q)
   );

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      unique case (dec.op)
         ALU_ADD: begin
            alu_res = a_q + opb;
            alu_ovf = (a_q[Msb] == opb[Msb]) && (alu_res[Msb] != a_q[Msb]);
         end
         ALU_SUB: begin
            alu_res = a_q - opb;
            alu_ovf = (a_q[Msb] != opb[Msb]) && (alu_res[Msb] != a_q[Msb]);
         end
         ALU_AND: alu_res = a_q & opb;
         ALU_OR:  alu_res = a_q | opb;
         ALU_SLT: alu_res = DataSize'($signed(a_q) < $signed(opb));
         default: alu_res = '0;
      endcase
   end

   // req is registered so it is low throughout reset and rises on the first edge after.
   always_comb begin
      state_d = state_q;
      req_d   = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (req_q && imem_ack) begin
               state_d = S_DECODE;
            end else begin
               req_d = 1'b1;
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC:   state_d = dec.halt ? S_HALT : S_WB;
         S_WB: begin
            state_d = S_FETCH;
            req_d   = 1'b1;
         end
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_FETCH;
         req_q          <= 1'b0;
         pc_q           <= '0;
         ir_q           <= '0;
         a_q            <= '0;
         b_q            <= '0;
         retire_valid_q <= 1'b0;
         retire_we_q    <= 1'b0;
         retire_wa_q    <= '0;
         retire_wd_q    <= '0;
         ovf_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         req_q          <= req_d;
         retire_valid_q <= (state_q == S_EXEC) && !dec.halt;
         case (state_q)
            S_FETCH: begin
               if (req_q && imem_ack) begin
                  ir_q <= imem_rdata;
               end
            end
            S_DECODE: begin
               a_q <= rf_a;
               b_q <= rf_b;
            end
            S_EXEC: begin
               // Retire report is captured here so it is visible during WB,
               // where the register write actually happens.
               if (!dec.halt) begin
                  retire_we_q <= exec_we;
                  retire_wa_q <= dest;
                  retire_wd_q <= alu_res;
                  if (dec.ovf_chk && alu_ovf) begin
                     ovf_q <= 1'b1;
                  end
               end
            end
            S_WB:    pc_q <= pc_q + PCsize'(1);
            default: ;
         endcase
      end
   end

   assign imem_req        = req_q;
   assign imem_addr       = pc_q;
   assign pc              = pc_q;
   assign retire_valid    = retire_valid_q;
   assign retire_we       = retire_we_q;
   assign retire_wa       = retire_wa_q;
   assign retire_wd       = retire_wd_q;
   assign overflow_sticky = ovf_q;
   assign halted          = (state_q == S_HALT);

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed, table-driven bench for mips_multicycle_core at default parameters.
module tb_mips_multicycle_core;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [5:0]  imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        retire_valid;
   logic        retire_we;
   logic [4:0]  retire_wa;
   logic [31:0] retire_wd;
   logic [5:0]  pc;
   logic        overflow_sticky;
   logic        halted;

   mips_multicycle_core #(
      .DataSize   (32),
      .PCsize     (6),
      .RegAddrSize(5)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .retire_valid   (retire_valid),
      .retire_we      (retire_we),
      .retire_wa      (retire_wa),
      .retire_wd      (retire_wd),
      .pc             (pc),
      .overflow_sticky(overflow_sticky),
      .halted         (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory model with programmable ack latency.
   logic [31:0] mem [64];
   int          ack_delay;
   int          wcnt;

   assign imem_ack   = imem_req && (wcnt >= ack_delay);
   assign imem_rdata = mem[imem_addr];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) wcnt <= 0;
      else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
      else wcnt <= 0;
   end

   typedef struct {
      logic [31:0] instr;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
   } vec_t;

   localparam int NV = 33;
   vec_t vecs [NV];

   int checks;
   int errors;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Waits for the next retire pulse; cycles = negedges elapsed.
   task automatic wait_retire(output int cycles);
      cycles = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         cycles++;
         if (retire_valid) break;
      end
      check("retire_valid seen", 64'(retire_valid), 64'(1));
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
   endtask

   task automatic hold_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   int cyc;
   int pulses;
   logic stable;

   initial begin
      checks    = 0;
      errors    = 0;
      ack_delay = 0;
      rst_n     = 1'b0;
      clear_mem();

      vecs[0] = '{32'h20010005, 1'b1, 5'd1, 32'h00000005};  // ADDI $1,$0,5
      vecs[1] = '{32'h2002FFFD, 1'b1, 5'd2, 32'hFFFFFFFD};  // ADDI $2,$0,-3
      vecs[2] = '{32'h00221820, 1'b1, 5'd3, 32'h00000002};  // ADD $3,$1,$2
      vecs[3] = '{32'h0041202A, 1'b1, 5'd4, 32'h00000001};  // SLT $4,$2,$1
      vecs[4] = '{32'h00222822, 1'b1, 5'd5, 32'h00000008};  // SUB $5,$1,$2
      vecs[5] = '{32'h00223824, 1'b1, 5'd7, 32'h00000005};  // AND $7,$1,$2
      vecs[6] = '{32'h00224025, 1'b1, 5'd8, 32'hFFFFFFFD};  // OR $8,$1,$2
      vecs[7] = '{32'h0022482A, 1'b1, 5'd9, 32'h00000000};  // SLT $9,$1,$2
      vecs[8] = '{32'h200A4000, 1'b1, 5'd10, 32'h00004000}; // ADDI $10,$0,0x4000
      for (int k = 0; k < 16; k++) begin                    // ADD $10,$10,$10
         vecs[9 + k] = '{32'h014A5020, 1'b1, 5'd10, 32'h00004000 << (k + 1)};
      end
      vecs[25] = '{32'h214BFFFF, 1'b1, 5'd11, 32'h3FFFFFFF}; // ADDI $11,$10,-1
      vecs[26] = '{32'h014B0820, 1'b1, 5'd1, 32'h7FFFFFFF};  // ADD $1,$10,$11
      vecs[27] = '{32'h20260001, 1'b0, 5'd6, 32'h80000000};  // ADDI $6,$1,1 ovf
      vecs[28] = '{32'h00C00020, 1'b0, 5'd0, 32'h00000000};  // ADD $0,$6,$0
      vecs[29] = '{32'h20000007, 1'b0, 5'd0, 32'h00000007};  // ADDI $0,$0,7
      vecs[30] = '{32'h00000020, 1'b0, 5'd0, 32'h00000000};  // ADD $0,$0,$0
      vecs[31] = '{32'h0C000000, 1'b0, 5'd0, 32'h00000000};  // unknown op
      vecs[32] = '{32'h00000000, 1'b0, 5'd0, 32'h00000000};  // SLL-as-NOP

      // Main program, zero-wait ack.
      for (int i = 0; i < NV; i++) mem[i] = vecs[i].instr;
      mem[NV] = 32'hFC000000;
      hold_reset();
      check("reset outputs",
            64'({imem_req, imem_addr, retire_valid, retire_we, retire_wa, retire_wd,
                 pc, overflow_sticky, halted}), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      check("req after release", 64'({imem_req, imem_addr}), 64'({1'b1, 6'd0}));

      for (int i = 0; i < NV; i++) begin
         wait_retire(cyc);
         if (i == 0) check("first retire cycle", 64'(cyc + 1), 64'(4));
         if (i == 1) check("second retire spacing", 64'(cyc), 64'(4));
         if (i == 27) check("overflow_sticky set", 64'(overflow_sticky), 64'(1));
         if (i == 26) check("overflow_sticky clear", 64'(overflow_sticky), 64'(0));
         check($sformatf("vec%0d we", i), 64'(retire_we), 64'(vecs[i].we));
         check($sformatf("vec%0d wa", i), 64'(retire_wa), 64'(vecs[i].wa));
         check($sformatf("vec%0d wd", i), 64'(retire_wd), 64'(vecs[i].wd));
         if (i == 1) begin
            @(negedge clk);
            check("pc after two", 64'(pc), 64'(2));
            check("retire pulse width", 64'(retire_valid), 64'(0));
         end
      end

      // HALT: freezes with req low, PC left at the HALT word.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (halted) break;
      end
      check("halted", 64'(halted), 64'(1));
      check("halt req low", 64'(imem_req), 64'(0));
      check("halt pc", 64'(pc), 64'(NV));
      pulses = 0;
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (retire_valid) pulses++;
         if (imem_req || !halted) stable = 1'b0;
      end
      check("halt no retire", 64'(pulses), 64'(0));
      check("halt frozen", 64'(stable), 64'(1));

      // Reset during EXECUTE of an ADD: no write, outputs clear, refetch from 0.
      clear_mem();
      mem[0] = 32'h20010005;  // ADDI $1,$0,5
      mem[1] = 32'h00211820;  // ADD $3,$1,$1
      hold_reset();
      rst_n = 1'b1;
      wait_retire(cyc);
      check("pre-abort wd", 64'(retire_wd), 64'(5));
      repeat (3) @(negedge clk);  // WB -> FETCH -> DECODE -> EXEC
      rst_n = 1'b0;
      #1;
      check("abort outputs",
            64'({imem_req, imem_addr, retire_valid, retire_we, retire_wa, retire_wd,
                 pc, overflow_sticky, halted}), 64'(0));
      mem[0] = 32'h00600020;  // ADD $0,$3,$0 reads $3
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("refetch addr", 64'({imem_req, imem_addr}), 64'({1'b1, 6'd0}));
      wait_retire(cyc);
      check("refetch wa", 64'(retire_wa), 64'(0));
      check("refetch $3 value", 64'(retire_wd), 64'(0));

      // Ack delayed 3 cycles: req/addr stable, retire on cycle 7.
      clear_mem();
      mem[0]    = 32'h20000007;  // ADDI $0,$0,7
      ack_delay = 3;
      hold_reset();
      rst_n  = 1'b1;
      stable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (!imem_req || imem_addr != 6'd0 || retire_valid) stable = 1'b0;
      end
      check("req stable while waiting", 64'(stable), 64'(1));
      wait_retire(cyc);
      check("delayed retire cycle", 64'(cyc + 4), 64'(7));
      check("addi $0 we", 64'(retire_we), 64'(0));
      check("addi $0 wd", 64'({retire_wa, retire_wd}), 64'({5'd0, 32'd7}));
      ack_delay = 0;

      // 64 NOPs: PC wraps back to 0.
      clear_mem();
      hold_reset();
      rst_n = 1'b1;
      for (int i = 0; i < 64; i++) wait_retire(cyc);
      check("pc before wrap", 64'(pc), 64'(63));
      @(negedge clk);
      check("pc wrapped", 64'(pc), 64'(0));
      check("imem_addr wrapped", 64'({imem_req, imem_addr}), 64'({1'b1, 6'd0}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1);
   end

endmodule
